// File: rtl/fetch_unit.sv
// Instruction-fetch datapath: IP, IR, SRAM address mux and saturating retired counter.
// Optional FETCH_JUMP_EN adds ip_load, a direct IP load from the cu operand address.
module fetch_unit #(
    parameter int              AW       = 8,
    parameter int              DW       = 16,
    parameter int              CNT_W    = 16,
    parameter logic [AW-1:0]   IP_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       adress_select,
    input  logic [AW-1:0]    adress,
    input  logic             ir_load,
    input  logic             ip_increment,
`ifdef FETCH_JUMP_EN
    input  logic             ip_load,
`endif
    input  logic [DW-1:0]    data_bus,
    output logic [AW-1:0]    abus,
    output logic [DW-1:0]    ir_data,
    output logic [AW-1:0]    ip,
    output logic             ip_wrap,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] ABUS_IP = 2'b00;
    localparam logic [1:0] ABUS_CU = 2'b01;

    logic [AW-1:0]    ip_q, ip_d;
    logic [DW-1:0]    ir_q, ir_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             inc_q;
    logic             inc_pulse;
    logic             jump;

`ifdef FETCH_JUMP_EN
    assign jump = ip_load;
`else
    assign jump = 1'b0;
`endif

    // cu holds ip_increment as a level for several cycles; only its rising edge advances IP
    assign inc_pulse = ip_increment & ~inc_q;

    always_comb begin
        ip_d   = ip_q;
        wrap_d = wrap_q;
        ret_d  = ret_q;
        ir_d   = ir_load ? data_bus : ir_q;
        if (jump) begin
            ip_d = adress;
        end else if (inc_pulse) begin
            ip_d = ip_q + AW'(1);
            if (&ip_q) begin
                wrap_d = 1'b1;
            end
            if (!(&ret_q)) begin
                ret_d = ret_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ip_q   <= IP_RESET;
            ir_q   <= '0;
            wrap_q <= 1'b0;
            ret_q  <= '0;
            inc_q  <= 1'b0;
        end else begin
            ip_q   <= ip_d;
            ir_q   <= ir_d;
            wrap_q <= wrap_d;
            ret_q  <= ret_d;
            inc_q  <= ip_increment;
        end
    end

    always_comb begin
        abus = '0;
        case (adress_select)
            ABUS_IP: abus = ip_q;
            ABUS_CU: abus = adress;
            default: abus = '0;
        endcase
    end

    // Bypass lets cu sample the new word on the same edge IR captures it
    assign ir_data = ir_load ? data_bus : ir_q;
    assign ip      = ip_q;
    assign ip_wrap = wrap_q;
    assign retired = ret_q;

endmodule
